// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants and prefetch queue entry type for the fetch path.
package riscv_fetch_pkg;
    localparam int          INSTR_W    = 32;
    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam int          FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with flush; storage is left unreset, only pointers and count reset.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  entry_t                     i_entry,
    output entry_t                     o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // DEPTH is a power of two, so pointer wrap is plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch from a combinational ROM into a prefetch queue,
// with branch redirect flushing the queue.
module instr_fetch_unit #(
    parameter int          DATA_WIDTH = riscv_fetch_pkg::INSTR_W,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = riscv_fetch_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = riscv_fetch_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_pc_plus4
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    typedef struct packed {
        logic [31:0]           pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [31:0]           r_fetch_pc;
    logic [ADDR_WIDTH+1:0] w_offset;
    logic [CW-1:0]         w_count;
    logic                  w_push;
    logic                  w_pop;
    entry_t                w_tail;
    entry_t                w_head;

    // low bits of the full subtraction equal the subtraction of the low bits
    assign w_offset     = r_fetch_pc[ADDR_WIDTH+1:0] - RESET_PC[ADDR_WIDTH+1:0];
    assign rom_addr     = ADDR_WIDTH'(w_offset >> 2);
    assign out_valid    = w_count != '0;
    assign w_pop        = out_valid && out_ready;
    assign w_push       = !redirect_valid && (w_count < CW'(FIFO_DEPTH) || w_pop);
    assign w_tail       = '{pc: r_fetch_pc, instr: rom_rd};
    assign out_instr    = out_valid ? w_head.instr : '0;
    assign out_pc       = out_valid ? w_head.pc : '0;
    assign out_pc_plus4 = out_valid ? w_head.pc + 32'd4 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_fetch_pc <= RESET_PC;
        else if (redirect_valid) r_fetch_pc <= redirect_pc & ~32'd3;
        else if (w_push)         r_fetch_pc <= r_fetch_pc + 32'd4;
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_entry (w_tail),
        .o_head  (w_head),
        .o_count (w_count)
    );
endmodule
